wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between three result producers: ALU (req 0), memory (req 1) and multiplier (req 2).
- Arbitration is round-robin. The block instantiates the existing 3:1 word multiplexer (mux_3to1) to steer data.
- The winning result is held in a one-entry output register with a valid/ready handshake toward the register file.
- A saturating counter reports write-port back-pressure for performance analysis.

Parameters:
- WORD_SIZE, `WORD_SIZE (32): data width of every result bus.
- REG_ADDR_W, 5: destination register index width.
- STALL_CNT_W, 16: width of the saturating stall counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- req_valid  in  3  per-requester result valid; bit i = requester i.
- req0_data / req1_data / req2_data  in  WORD_SIZE each  result data.
- req0_addr / req1_addr / req2_addr  in  REG_ADDR_W each  destination register.
- req_ready  out  3  one-hot grant/accept; transfer on req_valid[i] & req_ready[i].
- mux_sel  out  2  current grant index driven to the mux: 00 = req0, 01 = req1, 10 = req2. Never 11.
- wb_valid  out  1  output register holds a write.
- wb_ready  in  1  register file accepts the write.
- wb_data  out  WORD_SIZE  registered write data.
- wb_addr  out  REG_ADDR_W  registered write address.
- stall_cnt  out  STALL_CNT_W  cycles with wb_valid & ~wb_ready, saturating.

Behaviour:
- Reset (rst_n = 0 at a clock edge):
  - wb_valid = 0, wb_data = 0, wb_addr = 0, stall_cnt = 0.
  - Priority pointer last = 2, so req0 has highest priority first.
  - While rst_n = 0, req_ready = 000 and mux_sel = 00.
  - Reset mid-operation discards any held write and resets the pointer. No partial state survives.
- Load enable: load = ~wb_valid | wb_ready. Output slot is free or draining this cycle.
- Grant (combinational):
  - When load = 1, scan requesters in order last+1, last+2, last+3 (mod 3). Grant the first one with req_valid set.
  - req_ready = one-hot of the grant; mux_sel = grant index.
  - If load = 0 or no request is valid: req_ready = 000 and mux_sel holds its last granted value (registered copy).
- Transfer, at the edge where a grant occurs:
  - wb_data <= mux_3to1 output; wb_addr <= granted addr; last <= granted index.
  - Latency: request accepted in cycle N appears on wb_* in cycle N+1.
  - Sustained throughput is one write per cycle while wb_ready = 1.
- Register zero:
  - A granted transfer with addr = 0 is accepted (req_ready pulses) and the pointer advances.
  - wb_valid <= 0 for that cycle; the write is dropped. wb_data/wb_addr still update.
- Output hold:
  - If wb_valid & ~wb_ready, wb_valid/wb_data/wb_addr stay stable and no grant is issued.
  - If wb_valid & wb_ready and there is no new grant, wb_valid <= 0.
- Requester rules:
  - req_valid, data and addr must stay stable until accepted.
  - A valid that drops before acceptance is legal and simply loses arbitration.
- Pointer:
  - Changes only on transfer.
  - With all three valid continuously and wb_ready = 1, the grant order is 0,1,2,0,1,2…
- stall_cnt:
  - Increments by 1 each cycle wb_valid & ~wb_ready.
  - Holds at 2^STALL_CNT_W - 1; never wraps.
  - Cleared only by reset.

Test Plan:
1. Reset, then req_valid = 001, req0_data = 0x0000_00AA, req0_addr = 3, wb_ready = 1:
   - req_ready = 001 and mux_sel = 00 in cycle N.
   - Cycle N+1: wb_valid = 1, wb_data = 0x0000_00AA, wb_addr = 3.
2. req_valid = 111 held, wb_ready = 1, data 0x0 / 0xFFFF_FFFF / 0x5555_5555, addrs 1/2/3:
   - Grants 0,1,2,0,1,2 on consecutive cycles.
   - wb_data sequence 0x0, 0xFFFF_FFFF, 0x5555_5555, repeating.
3. wb_ready = 0 with wb_valid = 1 for 5 cycles while req_valid = 010:
   - req_ready = 000 and wb_* stable throughout; stall_cnt = 5.
   - With wb_ready = 1 for one cycle: req1 granted, its write appears the next cycle.
4. req0 granted with addr = 0:
   - req_ready[0] pulses.
   - The next cycle has wb_valid = 0.
   - The following grant goes to req1 if valid (pointer advanced).
5. rst_n = 0 for one cycle while wb_valid = 1 and stall_cnt = 7:
   - Next cycle wb_valid = 0, stall_cnt = 0, req_ready = 000.
   - After release, with req_valid = 110: first grant is req1.
6. STALL_CNT_W = 3, wb_valid = 1, wb_ready = 0 held 10 cycles:
   - stall_cnt reaches 7 and stays at 7.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the write-back arbiter and its producers / register file.
// slave = arbiter side, master = producers plus register-file side.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

interface wb_port_arbiter_if #(
  parameter int WORD_SIZE   = `WORD_SIZE,
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
);
  logic [2:0]             req_valid;
  logic [WORD_SIZE-1:0]   req0_data;
  logic [WORD_SIZE-1:0]   req1_data;
  logic [WORD_SIZE-1:0]   req2_data;
  logic [REG_ADDR_W-1:0]  req0_addr;
  logic [REG_ADDR_W-1:0]  req1_addr;
  logic [REG_ADDR_W-1:0]  req2_addr;
  logic [2:0]             req_ready;
  logic [1:0]             mux_sel;
  logic                   wb_valid;
  logic                   wb_ready;
  logic [WORD_SIZE-1:0]   wb_data;
  logic [REG_ADDR_W-1:0]  wb_addr;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport slave (
    input  req_valid, req0_data, req1_data, req2_data,
    input  req0_addr, req1_addr, req2_addr, wb_ready,
    output req_ready, mux_sel, wb_valid, wb_data, wb_addr, stall_cnt
  );

  modport master (
    output req_valid, req0_data, req1_data, req2_data,
    output req0_addr, req1_addr, req2_addr, wb_ready,
    input  req_ready, mux_sel, wb_valid, wb_data, wb_addr, stall_cnt
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU, memory
// and multiplier results, with a one-entry output register and a stall counter.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module mux_3to1 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_in0,
  input  logic [WIDTH-1:0] i_in1,
  input  logic [WIDTH-1:0] i_in2,
  input  logic [1:0]       i_sel,
  output logic [WIDTH-1:0] o_out
);
  always_comb begin
    o_out = '0;
    case (i_sel)
      2'd0:    o_out = i_in0;
      2'd1:    o_out = i_in1;
      2'd2:    o_out = i_in2;
      default: o_out = '0;
    endcase
  end
endmodule

module wb_port_arbiter #(
  parameter int WORD_SIZE   = `WORD_SIZE,
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  wb_port_arbiter_if.slave        bus
);
  logic [1:0]             r_last;
  logic [1:0]             r_sel;
  logic                   r_wb_valid;
  logic [WORD_SIZE-1:0]   r_wb_data;
  logic [REG_ADDR_W-1:0]  r_wb_addr;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic                   w_load;
  logic                   w_grant_vld;
  logic [1:0]             w_grant_idx;
  logic [1:0]             w_cand1;
  logic [1:0]             w_cand2;
  logic [1:0]             w_cand3;
  logic [1:0]             w_mux_sel;
  logic [WORD_SIZE-1:0]   w_mux_out;
  logic [REG_ADDR_W-1:0]  w_grant_addr;
  logic                   w_stall;

  function automatic logic [1:0] f_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Slot can take a new result when empty or when the current one drains now.
  assign w_load  = ~r_wb_valid | bus.wb_ready;
  assign w_stall = r_wb_valid & ~bus.wb_ready;

  always_comb begin
    w_cand1     = f_next(r_last);
    w_cand2     = f_next(w_cand1);
    w_cand3     = r_last;
    w_grant_vld = 1'b0;
    w_grant_idx = r_sel;
    if (rst_n && w_load) begin
      if (bus.req_valid[w_cand1]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand1;
      end else if (bus.req_valid[w_cand2]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand2;
      end else if (bus.req_valid[w_cand3]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand3;
      end
    end
  end

  // Without a grant the mux keeps pointing at the last winner.
  assign w_mux_sel = !rst_n ? 2'd0 : w_grant_idx;

  always_comb begin
    w_grant_addr = '0;
    case (w_mux_sel)
      2'd0:    w_grant_addr = bus.req0_addr;
      2'd1:    w_grant_addr = bus.req1_addr;
      2'd2:    w_grant_addr = bus.req2_addr;
      default: w_grant_addr = '0;
    endcase
  end

  mux_3to1 #(.WIDTH(WORD_SIZE)) u_mux (
    .i_in0 (bus.req0_data),
    .i_in1 (bus.req1_data),
    .i_in2 (bus.req2_data),
    .i_sel (w_mux_sel),
    .o_out (w_mux_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last      <= 2'd2;
      r_sel       <= 2'd0;
      r_wb_valid  <= 1'b0;
      r_wb_data   <= '0;
      r_wb_addr   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_grant_vld) begin
        // Writes to register zero are consumed but never presented.
        r_wb_valid <= (w_grant_addr != '0);
        r_wb_data  <= w_mux_out;
        r_wb_addr  <= w_grant_addr;
        r_last     <= w_grant_idx;
        r_sel      <= w_grant_idx;
      end else if (bus.wb_ready) begin
        r_wb_valid <= 1'b0;
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
      end
    end
  end

  assign bus.req_ready = w_grant_vld ? (3'b001 << w_grant_idx) : 3'b000;
  assign bus.mux_sel   = w_mux_sel;
  assign bus.wb_valid  = r_wb_valid;
  assign bus.wb_data   = r_wb_data;
  assign bus.wb_addr   = r_wb_addr;
  assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: one task per scenario, inline checks.
module tb_wb_port_arbiter;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  wb_port_arbiter_if #(.WORD_SIZE(32), .REG_ADDR_W(5), .STALL_CNT_W(16)) bus ();
  wb_port_arbiter_if #(.WORD_SIZE(32), .REG_ADDR_W(5), .STALL_CNT_W(3))  bus6 ();

  wb_port_arbiter #(.WORD_SIZE(32), .REG_ADDR_W(5), .STALL_CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  wb_port_arbiter #(.WORD_SIZE(32), .REG_ADDR_W(5), .STALL_CNT_W(3)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.req_valid  = 3'b000;
    bus.req0_data  = '0; bus.req1_data = '0; bus.req2_data = '0;
    bus.req0_addr  = '0; bus.req1_addr = '0; bus.req2_addr = '0;
    bus.wb_ready   = 1'b1;
    bus6.req_valid = 3'b000;
    bus6.req0_data = '0; bus6.req1_data = '0; bus6.req2_data = '0;
    bus6.req0_addr = '0; bus6.req1_addr = '0; bus6.req2_addr = '0;
    bus6.wb_ready  = 1'b1;
  endtask

  // Leaves the caller just after a rising edge with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus.req_valid = 3'b111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (bus.req_ready !== 3'b000) begin n_err++; $display("FAIL reset_req_ready got %b want 000", bus.req_ready); end
    n_vec++; if (bus.mux_sel !== 2'b00) begin n_err++; $display("FAIL reset_mux_sel got %b want 00", bus.mux_sel); end
    n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid got %b want 0", bus.wb_valid); end
    n_vec++; if (bus.wb_data !== 32'h0 || bus.wb_addr !== 5'd0) begin n_err++; $display("FAIL reset_wb_data_addr got %h/%0d want 0/0", bus.wb_data, bus.wb_addr); end
    n_vec++; if (bus.stall_cnt !== 16'd0) begin n_err++; $display("FAIL reset_stall got %0d want 0", bus.stall_cnt); end
  endtask

  task automatic test_single();
    do_reset();
    bus.req_valid = 3'b001;
    bus.req0_data = 32'h0000_00AA;
    bus.req0_addr = 5'd3;
    bus.wb_ready  = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.req_ready !== 3'b001) begin n_err++; $display("FAIL single_grant got %b want 001", bus.req_ready); end
    n_vec++; if (bus.mux_sel !== 2'b00) begin n_err++; $display("FAIL single_sel got %b want 00", bus.mux_sel); end
    @(posedge clk); #1;
    bus.req_valid = 3'b000;
    n_vec++; if (bus.wb_valid !== 1'b1) begin n_err++; $display("FAIL single_wb_valid got %b want 1", bus.wb_valid); end
    n_vec++; if (bus.wb_data !== 32'h0000_00AA) begin n_err++; $display("FAIL single_wb_data got %h want 000000aa", bus.wb_data); end
    n_vec++; if (bus.wb_addr !== 5'd3) begin n_err++; $display("FAIL single_wb_addr got %0d want 3", bus.wb_addr); end
    @(posedge clk); #1;
    n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got %b want 0", bus.wb_valid); end
  endtask

  task automatic test_round_robin();
    logic [31:0] d [3];
    logic [2:0]  exp_rdy;
    logic [1:0]  exp_sel;
    d[0] = 32'h0000_0000; d[1] = 32'hFFFF_FFFF; d[2] = 32'h5555_5555;
    do_reset();
    bus.req0_data = d[0]; bus.req1_data = d[1]; bus.req2_data = d[2];
    bus.req0_addr = 5'd1; bus.req1_addr = 5'd2; bus.req2_addr = 5'd3;
    bus.req_valid = 3'b111;
    bus.wb_ready  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_sel = 2'(i % 3);
      exp_rdy = 3'b001 << exp_sel;
      @(negedge clk);
      n_vec++; if (bus.req_ready !== exp_rdy || bus.mux_sel !== exp_sel) begin n_err++; $display("FAIL rr_grant[%0d] got %b/%0d want %b/%0d", i, bus.req_ready, bus.mux_sel, exp_rdy, exp_sel); end
      @(posedge clk); #1;
      n_vec++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== d[exp_sel]) begin n_err++; $display("FAIL rr_data[%0d] got %b/%h want 1/%h", i, bus.wb_valid, bus.wb_data, d[exp_sel]); end
    end
    bus.req_valid = 3'b000;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.req_valid = 3'b001; bus.req0_data = 32'h11; bus.req0_addr = 5'd4;
    bus.wb_ready  = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 3'b010; bus.req1_data = 32'h22; bus.req1_addr = 5'd5;
    bus.wb_ready  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++; if (bus.req_ready !== 3'b000) begin n_err++; $display("FAIL bp_no_grant[%0d] got %b want 000", i, bus.req_ready); end
      n_vec++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h11 || bus.wb_addr !== 5'd4) begin n_err++; $display("FAIL bp_hold[%0d] got %b/%h/%0d want 1/11/4", i, bus.wb_valid, bus.wb_data, bus.wb_addr); end
      @(posedge clk); #1;
    end
    n_vec++; if (bus.stall_cnt !== 16'd5) begin n_err++; $display("FAIL bp_stall got %0d want 5", bus.stall_cnt); end
    bus.wb_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.req_ready !== 3'b010 || bus.mux_sel !== 2'b01) begin n_err++; $display("FAIL bp_release_grant got %b/%0d want 010/1", bus.req_ready, bus.mux_sel); end
    @(posedge clk); #1;
    bus.req_valid = 3'b000;
    n_vec++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h22 || bus.wb_addr !== 5'd5) begin n_err++; $display("FAIL bp_release_data got %b/%h/%0d want 1/22/5", bus.wb_valid, bus.wb_data, bus.wb_addr); end
    n_vec++; if (bus.stall_cnt !== 16'd5) begin n_err++; $display("FAIL bp_stall_after got %0d want 5", bus.stall_cnt); end
  endtask

  task automatic test_reg_zero();
    do_reset();
    bus.req0_data = 32'h33; bus.req0_addr = 5'd0;
    bus.req1_data = 32'h44; bus.req1_addr = 5'd6;
    bus.req_valid = 3'b011;
    bus.wb_ready  = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.req_ready !== 3'b001) begin n_err++; $display("FAIL r0_grant got %b want 001", bus.req_ready); end
    @(posedge clk); #1;
    n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL r0_dropped got %b want 0", bus.wb_valid); end
    n_vec++; if (bus.wb_data !== 32'h33 || bus.wb_addr !== 5'd0) begin n_err++; $display("FAIL r0_regs got %h/%0d want 33/0", bus.wb_data, bus.wb_addr); end
    bus.req0_data = 32'h55; bus.req0_addr = 5'd7;
    @(negedge clk);
    n_vec++; if (bus.req_ready !== 3'b010) begin n_err++; $display("FAIL r0_next_grant got %b want 010", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 3'b000;
    n_vec++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h44 || bus.wb_addr !== 5'd6) begin n_err++; $display("FAIL r0_next_data got %b/%h/%0d want 1/44/6", bus.wb_valid, bus.wb_data, bus.wb_addr); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.req_valid = 3'b001; bus.req0_data = 32'h66; bus.req0_addr = 5'd8;
    bus.wb_ready  = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 3'b000;
    bus.wb_ready  = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    n_vec++; if (bus.stall_cnt !== 16'd7 || bus.wb_valid !== 1'b1) begin n_err++; $display("FAIL mr_pre got %0d/%b want 7/1", bus.stall_cnt, bus.wb_valid); end
    rst_n = 1'b0;
    bus.req1_data = 32'h77; bus.req1_addr = 5'd9;
    bus.req2_data = 32'h88; bus.req2_addr = 5'd10;
    bus.req_valid = 3'b110;
    @(negedge clk);
    n_vec++; if (bus.req_ready !== 3'b000 || bus.mux_sel !== 2'b00) begin n_err++; $display("FAIL mr_gated got %b/%0d want 000/0", bus.req_ready, bus.mux_sel); end
    @(posedge clk); #1;
    n_vec++; if (bus.wb_valid !== 1'b0 || bus.stall_cnt !== 16'd0) begin n_err++; $display("FAIL mr_cleared got %b/%0d want 0/0", bus.wb_valid, bus.stall_cnt); end
    rst_n = 1'b1;
    bus.wb_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.req_ready !== 3'b010 || bus.mux_sel !== 2'b01) begin n_err++; $display("FAIL mr_first_grant got %b/%0d want 010/1", bus.req_ready, bus.mux_sel); end
    @(posedge clk); #1;
    bus.req_valid = 3'b000;
    n_vec++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h77) begin n_err++; $display("FAIL mr_first_data got %b/%h want 1/77", bus.wb_valid, bus.wb_data); end
  endtask

  task automatic test_saturate();
    logic [2:0] exp;
    do_reset();
    bus6.req_valid = 3'b001; bus6.req0_data = 32'h9; bus6.req0_addr = 5'd1;
    bus6.wb_ready  = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (bus6.wb_valid !== 1'b1) begin n_err++; $display("FAIL sat_load got %b want 1", bus6.wb_valid); end
    bus6.req_valid = 3'b000;
    bus6.wb_ready  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      exp = (i + 1 > 7) ? 3'd7 : 3'(i + 1);
      n_vec++; if (bus6.stall_cnt !== exp) begin n_err++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, bus6.stall_cnt, exp); end
    end
    bus6.wb_ready = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reg_zero();
    test_mid_reset();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
